// File: rtl/sdrc_stream_pkg.sv
// Shared constants and helpers for the SDRAM app-side stream adapter.
//   BYTE_W       : width of one host stream byte
//   fifo_entry_w : FIFO entry width for a data word plus optional byte enables
package sdrc_stream_pkg;

    localparam int unsigned BYTE_W = 8;

    // Entry width for a FIFO carrying dw data bits and bw enable bits.
    function automatic int unsigned fifo_entry_w(input int unsigned dw, input int unsigned bw);
        return dw + bw;
    endfunction

endpackage

// File: rtl/sdrc_sync_fifo.sv
// Single-clock FIFO with show-ahead head and extra-MSB pointers.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request/data (accepted when not full, or full with a pop)
//   pop          : consume head (ignored when empty)
//   dout         : head entry (don't-care while empty)
//   full, empty  : status
//   count        : occupancy 0..2**AW
module sdrc_sync_fifo #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH = 2**AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage; contents are meaningless once pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sdrc_app_stream_if.sv
// Application-side stream adapter for the SDRAM controller app data port.
//   Write: host bytes (s_wr_*) packed little-endian into APP_DW words with
//          active-low enables, queued, presented on app_wr_data/app_wr_en_n,
//          popped by app_wr_next. wr_flush pushes a partial word.
//   Read : app_rd_data words captured on app_rd_valid, unpacked to m_rd_* bytes.
//   Status: wr_words, rd_space occupancy; sticky wr_underrun / rd_overrun.
module sdrc_app_stream_if
    import sdrc_stream_pkg::*;
#(
    parameter int unsigned APP_DW = 32,
    parameter int unsigned APP_BW = 4,
    parameter int unsigned WR_AW  = 3,
    parameter int unsigned RD_AW  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        s_wr_data,
    input  logic              s_wr_valid,
    output logic              s_wr_ready,
    input  logic              wr_flush,
    output logic [APP_DW-1:0] app_wr_data,
    output logic [APP_BW-1:0] app_wr_en_n,
    input  logic              app_wr_next,
    output logic [WR_AW:0]    wr_words,
    input  logic [APP_DW-1:0] app_rd_data,
    input  logic              app_rd_valid,
    output logic [RD_AW:0]    rd_space,
    output logic [7:0]        m_rd_data,
    output logic              m_rd_valid,
    input  logic              m_rd_ready,
    output logic              wr_underrun,
    output logic              rd_overrun
);

    localparam int unsigned CW   = $clog2(APP_BW);
    localparam int unsigned WF_W = fifo_entry_w(APP_DW, APP_BW);
    localparam int unsigned RF_W = fifo_entry_w(APP_DW, 0);

    // ---------------- write path ----------------
    logic [APP_DW-1:0] wr_buf;
    logic [CW-1:0]     wr_cnt;
    logic              flush_pend;
    logic [APP_DW-1:0] buf_upd;
    logic [CW:0]       fill;
    logic [APP_BW-1:0] part_en_n;
    logic              byte_acc;
    logic              word_done;
    logic              flush_req;
    logic              wf_push;
    logic [WF_W-1:0]   wf_dout;
    logic              wf_full;
    logic              wf_empty;

    assign s_wr_ready = ~flush_pend & ~((wr_cnt == CW'(APP_BW-1)) & wf_full);
    assign byte_acc   = s_wr_valid & s_wr_ready;
    assign word_done  = byte_acc & (wr_cnt == CW'(APP_BW-1));
    // A pending flush retries each cycle; a new flush is moot if this byte completes the word.
    assign flush_req  = flush_pend | (wr_flush & ~word_done & (fill != '0));
    assign wf_push    = word_done | (flush_req & ~wf_full);

    // Merge this cycle's byte and derive lane enables from the resulting fill.
    always_comb begin
        buf_upd   = wr_buf;
        part_en_n = '1;
        if (byte_acc) buf_upd[BYTE_W*wr_cnt +: BYTE_W] = s_wr_data;
        fill = {1'b0, wr_cnt} + (CW+1)'(byte_acc);
        for (int unsigned k = 0; k < APP_BW; k++) begin
            part_en_n[k] = ((CW+1)'(k) >= fill);
        end
    end

    // Packer state; the buffer clears on push so unfilled lanes read as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_buf     <= '0;
            wr_cnt     <= '0;
            flush_pend <= 1'b0;
        end else if (wf_push) begin
            wr_buf     <= '0;
            wr_cnt     <= '0;
            flush_pend <= 1'b0;
        end else begin
            wr_buf     <= buf_upd;
            wr_cnt     <= fill[CW-1:0];
            flush_pend <= flush_req;
        end
    end

    sdrc_sync_fifo #(.W(WF_W), .AW(WR_AW)) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wf_push),
        .din     ({part_en_n, buf_upd}),
        .pop     (app_wr_next),
        .dout    (wf_dout),
        .full    (wf_full),
        .empty   (wf_empty),
        .count   (wr_words)
    );

    assign app_wr_data = wf_empty ? '0 : wf_dout[APP_DW-1:0];
    assign app_wr_en_n = wf_empty ? '1 : wf_dout[WF_W-1:APP_DW];

    // ---------------- read path ----------------
    logic [RF_W-1:0]   rf_dout;
    logic              rf_full;
    logic              rf_empty;
    logic [RD_AW:0]    rf_count;
    logic [APP_DW-1:0] cur_word;
    logic [CW-1:0]     rd_idx;
    logic [CW-1:0]     rd_idx_nxt;
    logic              take;
    logic              last_take;
    logic              load;

    assign take       = m_rd_valid & m_rd_ready;
    assign last_take  = take & (rd_idx == CW'(APP_BW-1));
    // Reload on the edge the last byte leaves so the byte stream has no bubble.
    assign load       = (~m_rd_valid | last_take) & ~rf_empty;
    assign rd_idx_nxt = rd_idx + CW'(1);

    sdrc_sync_fifo #(.W(RF_W), .AW(RD_AW)) u_rd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (app_rd_valid),
        .din     (app_rd_data),
        .pop     (load),
        .dout    (rf_dout),
        .full    (rf_full),
        .empty   (rf_empty),
        .count   (rf_count)
    );

    assign rd_space = (RD_AW+1)'(2**RD_AW) - rf_count;

    // Unpacker: current word, lane index and registered byte output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_word   <= '0;
            rd_idx     <= '0;
            m_rd_valid <= 1'b0;
            m_rd_data  <= '0;
        end else if (load) begin
            cur_word   <= rf_dout;
            rd_idx     <= '0;
            m_rd_valid <= 1'b1;
            m_rd_data  <= rf_dout[BYTE_W-1:0];
        end else if (last_take) begin
            m_rd_valid <= 1'b0;
        end else if (take) begin
            rd_idx     <= rd_idx_nxt;
            m_rd_data  <= cur_word[BYTE_W*rd_idx_nxt +: BYTE_W];
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_underrun <= 1'b0;
            rd_overrun  <= 1'b0;
        end else begin
            if (app_wr_next & wf_empty)             wr_underrun <= 1'b1;
            if (app_rd_valid & rf_full & ~load)     rd_overrun  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdrc_app_stream_if.sv
// Self-checking bench for sdrc_app_stream_if: directed steps followed by
// randomized write and read traffic scored against queue-based models.
module tb_sdrc_app_stream_if;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_wr_data;
    logic        s_wr_valid;
    logic        s_wr_ready;
    logic        wr_flush;
    logic [31:0] app_wr_data;
    logic [3:0]  app_wr_en_n;
    logic        app_wr_next;
    logic [3:0]  wr_words;
    logic [31:0] app_rd_data;
    logic        app_rd_valid;
    logic [3:0]  rd_space;
    logic [7:0]  m_rd_data;
    logic        m_rd_valid;
    logic        m_rd_ready;
    logic        wr_underrun;
    logic        rd_overrun;

    int checks = 0;
    int errors = 0;

    sdrc_app_stream_if dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_wr_data    (s_wr_data),
        .s_wr_valid   (s_wr_valid),
        .s_wr_ready   (s_wr_ready),
        .wr_flush     (wr_flush),
        .app_wr_data  (app_wr_data),
        .app_wr_en_n  (app_wr_en_n),
        .app_wr_next  (app_wr_next),
        .wr_words     (wr_words),
        .app_rd_data  (app_rd_data),
        .app_rd_valid (app_rd_valid),
        .rd_space     (rd_space),
        .m_rd_data    (m_rd_data),
        .m_rd_valid   (m_rd_valid),
        .m_rd_ready   (m_rd_ready),
        .wr_underrun  (wr_underrun),
        .rd_overrun   (rd_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic put_byte(input logic [7:0] b);
        s_wr_data  = b;
        s_wr_valid = 1'b1;
        step();
        s_wr_valid = 1'b0;
    endtask

    task automatic pop_word();
        app_wr_next = 1'b1;
        step();
        app_wr_next = 1'b0;
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        logic [7:0]  bytes [36];
        logic [31:0] words [10];
        logic [7:0]  rq [$];
        logic [35:0] mq [$];
        logic [7:0]  part [4];
        int          cnt;
        bit          pend;
        bit          under;

        reset_n = 1'b0; s_wr_data = '0; s_wr_valid = 1'b0; wr_flush = 1'b0;
        app_wr_next = 1'b0; app_rd_data = '0; app_rd_valid = 1'b0; m_rd_ready = 1'b0;
        #2;
        chk("rst_ready",   64'(s_wr_ready), 64'h1);
        chk("rst_wr_data", 64'(app_wr_data), 64'h0);
        chk("rst_en_n",    64'(app_wr_en_n), 64'hF);
        chk("rst_words",   64'(wr_words), 64'h0);
        chk("rst_space",   64'(rd_space), 64'h8);
        chk("rst_mvalid",  64'(m_rd_valid), 64'h0);
        chk("rst_mdata",   64'(m_rd_data), 64'h0);
        chk("rst_under",   64'(wr_underrun), 64'h0);
        chk("rst_over",    64'(rd_overrun), 64'h0);
        do_reset();

        // Two full words, little-endian packing.
        for (int i = 0; i < 8; i++) put_byte(8'(8'h11 * (i + 1)));
        chk("pk_words", 64'(wr_words), 64'h2);
        chk("pk_head0", 64'(app_wr_data), 64'(pack4(8'h11, 8'h22, 8'h33, 8'h44)));
        chk("pk_en0",   64'(app_wr_en_n), 64'h0);
        pop_word();
        chk("pk_head1", 64'(app_wr_data), 64'(pack4(8'h55, 8'h66, 8'h77, 8'h88)));
        chk("pk_en1",   64'(app_wr_en_n), 64'h0);
        pop_word();
        chk("pk_empty_en", 64'(app_wr_en_n), 64'hF);

        // Partial flush, then a clean full word proves the byte counter restarted.
        put_byte(8'hAA); put_byte(8'hBB);
        wr_flush = 1'b1; step(); wr_flush = 1'b0;
        chk("fl_words", 64'(wr_words), 64'h1);
        chk("fl_head",  64'(app_wr_data), 64'h0000BBAA);
        chk("fl_en",    64'(app_wr_en_n), 64'hC);
        for (int i = 0; i < 4; i++) put_byte(8'(i + 1));
        pop_word();
        chk("fl_next_head", 64'(app_wr_data), 64'(pack4(8'h01, 8'h02, 8'h03, 8'h04)));
        chk("fl_next_en",   64'(app_wr_en_n), 64'h0);
        pop_word();

        // Fill the write FIFO, then block on the completing byte.
        for (int i = 0; i < 32; i++) begin
            bytes[i] = 8'($urandom);
            put_byte(bytes[i]);
        end
        chk("full_words", 64'(wr_words), 64'h8);
        for (int i = 32; i < 35; i++) begin
            bytes[i] = 8'($urandom);
            put_byte(bytes[i]);
        end
        chk("full_ready", 64'(s_wr_ready), 64'h0);
        pop_word();
        chk("full_ready_back", 64'(s_wr_ready), 64'h1);
        chk("full_words7", 64'(wr_words), 64'h7);
        bytes[35] = 8'($urandom);
        put_byte(bytes[35]);
        chk("full_words8", 64'(wr_words), 64'h8);
        chk("full_under", 64'(wr_underrun), 64'h0);
        for (int w = 1; w < 9; w++) begin
            chk("full_drain", 64'(app_wr_data),
                64'(pack4(bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3])));
            pop_word();
        end
        chk("empty_under0", 64'(wr_underrun), 64'h0);
        pop_word();
        chk("empty_under1", 64'(wr_underrun), 64'h1);
        chk("empty_en",     64'(app_wr_en_n), 64'hF);
        chk("empty_data",   64'(app_wr_data), 64'h0);
        do_reset();

        // Read latency: strobe in cycle N, first byte valid in cycle N+2.
        m_rd_ready = 1'b1;
        app_rd_data = 32'hDDCCBBAA; app_rd_valid = 1'b1;
        step();
        app_rd_valid = 1'b0;
        chk("lat_n1_valid", 64'(m_rd_valid), 64'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("lat_valid", 64'(m_rd_valid), 64'h1);
            chk("lat_byte",  64'(m_rd_data), 64'(8'hAA + 8'(i * 8'h11)));
            step();
        end
        chk("lat_done", 64'(m_rd_valid), 64'h0);

        // Overrun: one word parks in the unpacker, eight fill the FIFO, the tenth drops.
        m_rd_ready = 1'b0;
        for (int w = 0; w < 10; w++) begin
            words[w] = $urandom;
            app_rd_data = words[w]; app_rd_valid = 1'b1;
            step();
        end
        app_rd_valid = 1'b0;
        step();
        chk("ovr_flag",  64'(rd_overrun), 64'h1);
        chk("ovr_space", 64'(rd_space), 64'h0);
        chk("ovr_hold_valid", 64'(m_rd_valid), 64'h1);
        chk("ovr_hold_data",  64'(m_rd_data), 64'(words[0][7:0]));
        for (int w = 0; w < 9; w++)
            for (int k = 0; k < 4; k++) rq.push_back(words[w][8*k +: 8]);
        m_rd_ready = 1'b1;
        for (int c = 0; c < 100 && rq.size() > 0; c++) begin
            if (m_rd_valid) chk("ovr_drain", 64'(m_rd_data), 64'(rq.pop_front()));
            step();
        end
        chk("ovr_drain_left", 64'(rq.size()), 64'h0);
        chk("ovr_after_valid", 64'(m_rd_valid), 64'h0);
        chk("ovr_after_space", 64'(rd_space), 64'h8);
        m_rd_ready = 1'b0;
        do_reset();

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 14; i++) put_byte(8'($urandom));
        app_rd_data = $urandom; app_rd_valid = 1'b1; step(); app_rd_valid = 1'b0;
        step();
        chk("mid_pre_words", 64'(wr_words), 64'h3);
        chk("mid_pre_valid", 64'(m_rd_valid), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_words", 64'(wr_words), 64'h0);
        chk("mid_valid", 64'(m_rd_valid), 64'h0);
        chk("mid_en",    64'(app_wr_en_n), 64'hF);
        chk("mid_space", 64'(rd_space), 64'h8);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) put_byte(8'(8'hC1 + i));
        chk("mid_fresh", 64'(app_wr_data), 64'(pack4(8'hC1, 8'hC2, 8'hC3, 8'hC4)));
        pop_word();

        // Random write traffic against a byte/word queue model.
        cnt = 0; pend = 0; under = 0;
        for (int k = 0; k < 4; k++) part[k] = '0;
        for (int c = 0; c < 800; c++) begin
            bit          exp_ready, v, nx, fl, acc, full0, empty0, have;
            logic [7:0]  b;
            logic [35:0] nw;
            exp_ready = !pend && !(cnt == 3 && mq.size() == 8);
            chk("rw_ready", 64'(s_wr_ready), 64'(exp_ready));
            chk("rw_words", 64'(wr_words), 64'(mq.size()));
            chk("rw_data",  64'(app_wr_data), (mq.size() > 0) ? 64'(mq[0][31:0]) : 64'h0);
            chk("rw_en",    64'(app_wr_en_n), (mq.size() > 0) ? 64'(mq[0][35:32]) : 64'hF);
            chk("rw_under", 64'(wr_underrun), 64'(under));
            v  = ($urandom_range(0, 3) != 0);
            nx = (c < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            fl = ($urandom_range(0, 9) == 0);
            b  = 8'($urandom);
            s_wr_valid = v; s_wr_data = b; app_wr_next = nx; wr_flush = fl;
            acc = v && exp_ready;
            full0 = (mq.size() == 8);
            empty0 = (mq.size() == 0);
            have = 0;
            nw = '0;
            if (acc) begin
                part[cnt] = b;
                cnt++;
            end
            if (acc && cnt == 4) begin
                nw = {4'h0, part[3], part[2], part[1], part[0]};
                have = 1;
            end else if (pend || (fl && cnt > 0)) begin
                if (!full0) begin
                    for (int k = 0; k < 4; k++) begin
                        nw[32+k] = (k >= cnt);
                        nw[8*k +: 8] = (k < cnt) ? part[k] : 8'h00;
                    end
                    have = 1;
                    pend = 0;
                end else begin
                    pend = 1;
                end
            end
            if (have) begin
                cnt = 0;
                for (int k = 0; k < 4; k++) part[k] = '0;
            end
            if (nx) begin
                if (empty0) under = 1;
                else void'(mq.pop_front());
            end
            if (have) mq.push_back(nw);
            step();
        end
        s_wr_valid = 1'b0; app_wr_next = 1'b0; wr_flush = 1'b0;
        do_reset();

        // Random read traffic, kept below FIFO capacity; checks order and stall stability.
        begin
            int          sent;
            int          recv;
            bit          last_v, last_taken, rdy, snd;
            logic [7:0]  last_d;
            logic [31:0] w;
            sent = 0; recv = 0; last_v = 0; last_taken = 0; last_d = '0;
            rq.delete();
            for (int c = 0; c < 600; c++) begin
                if (last_v && !last_taken) begin
                    chk("rr_hold_valid", 64'(m_rd_valid), 64'h1);
                    chk("rr_hold_data",  64'(m_rd_data), 64'(last_d));
                end
                rdy = (c < 580) ? bit'($urandom_range(0, 1)) : 1'b1;
                m_rd_ready = rdy;
                last_v = m_rd_valid; last_d = m_rd_data; last_taken = m_rd_valid && rdy;
                if (last_taken) begin
                    if (rq.size() == 0) chk("rr_extra", 64'h1, 64'h0);
                    else chk("rr_byte", 64'(m_rd_data), 64'(rq.pop_front()));
                    recv++;
                end
                snd = (c < 560) && ((sent - recv / 4) <= 7) && ($urandom_range(0, 2) != 0);
                w = $urandom;
                app_rd_valid = snd; app_rd_data = w;
                if (snd) begin
                    sent++;
                    for (int k = 0; k < 4; k++) rq.push_back(w[8*k +: 8]);
                end
                step();
            end
            app_rd_valid = 1'b0;
            m_rd_ready = 1'b1;
            for (int c = 0; c < 200 && rq.size() > 0; c++) begin
                if (m_rd_valid) chk("rr_drain", 64'(m_rd_data), 64'(rq.pop_front()));
                step();
            end
            chk("rr_left",  64'(rq.size()), 64'h0);
            chk("rr_over",  64'(rd_overrun), 64'h0);
            chk("rr_space", 64'(rd_space), 64'h8);
            chk("rr_valid", 64'(m_rd_valid), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
